// File: rtl/ctrl_hazard_pipe_pkg.sv
// Shared constants and types for the control-signal hazard pipeline.
// Control word: {Branch_outcome,PCSrc,WBSrc,RegWrite,MemWrite,MemRead,ALUOp,ALUSrc}.
package ctrl_hazard_pipe_pkg;

  localparam int BR_W   = 1;
  localparam int PCS_W  = 2;
  localparam int WBS_W  = 2;
  localparam int RW_W   = 1;
  localparam int MW_W   = 1;
  localparam int MR_W   = 1;
  localparam int ALUOP_W = 4;
  localparam int ALUS_W = 1;

  localparam int ALUS_OFF  = 0;
  localparam int ALUOP_OFF = ALUS_OFF + ALUS_W;
  localparam int MR_OFF    = ALUOP_OFF + ALUOP_W;
  localparam int MW_OFF    = MR_OFF + MR_W;
  localparam int RW_OFF    = MW_OFF + MW_W;
  localparam int WBS_OFF   = RW_OFF + RW_W;
  localparam int PCS_OFF   = WBS_OFF + WBS_W;
  localparam int BR_OFF    = PCS_OFF + PCS_W;

  localparam int CTRL_WIDTH = BR_OFF + BR_W;

  localparam logic [CTRL_WIDTH-1:0] INVALID_VECTOR = '0;

  typedef struct packed {
    logic [BR_W-1:0]    branch_outcome;
    logic [PCS_W-1:0]   pc_src;
    logic [WBS_W-1:0]   wb_src;
    logic [RW_W-1:0]    reg_write;
    logic [MW_W-1:0]    mem_write;
    logic [MR_W-1:0]    mem_read;
    logic [ALUOP_W-1:0] alu_op;
    logic [ALUS_W-1:0]  alu_src;
  } ctrl_word_t;

  typedef enum logic [1:0] {
    MODE_LOAD,
    MODE_HOLD,
    MODE_BUBBLE
  } stage_mode_e;

endpackage

// File: rtl/ctrl_hazard_pipe_if.sv
// ID-side control input and per-stage control output bundle.
interface ctrl_hazard_pipe_if
  import ctrl_hazard_pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_WIDTH,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 8
);

  logic [CTRL_W-1:0]       ctrl_in;
  logic                    valid_in;
  logic                    stall;
  logic                    bubble_req;
  logic                    flush;
  logic                    cnt_clr;
  logic [DEPTH*CTRL_W-1:0] ctrl_out;
  logic [DEPTH-1:0]        valid_out;
  logic [CNT_W-1:0]        bubble_cnt;
  logic                    stall_timeout;

  modport master (
    output ctrl_in, valid_in, stall,
    output bubble_req, flush, cnt_clr,
    input  ctrl_out, valid_out,
    input  bubble_cnt, stall_timeout
  );

  modport slave (
    input  ctrl_in, valid_in, stall,
    input  bubble_req, flush, cnt_clr,
    output ctrl_out, valid_out,
    output bubble_cnt, stall_timeout
  );

endinterface

// File: rtl/ctrl_pipe_stage.sv
// One registered control stage: load, hold, or bubble.
module ctrl_pipe_stage
  import ctrl_hazard_pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_WIDTH,
  parameter logic [CTRL_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  stage_mode_e       mode_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              valid_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              valid_o
);

  logic [CTRL_W-1:0] ctrl_q;
  logic              valid_q;

  // An invalid load also writes BUBBLE_VAL so idle stages stay clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= BUBBLE_VAL;
      valid_q <= 1'b0;
    end else begin
      unique case (mode_i)
        MODE_LOAD: begin
          ctrl_q  <= valid_i ? ctrl_i : BUBBLE_VAL;
          valid_q <= valid_i;
        end
        MODE_BUBBLE: begin
          ctrl_q  <= BUBBLE_VAL;
          valid_q <= 1'b0;
        end
        default: begin
          ctrl_q  <= ctrl_q;
          valid_q <= valid_q;
        end
      endcase
    end
  end

  assign ctrl_o  = ctrl_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/ctrl_hazard_pipe.sv
// Control-word pipeline with stall hold, bubble insert and branch flush,
// plus a saturating bubble counter and a sticky over-long-stall flag.
module ctrl_hazard_pipe
  import ctrl_hazard_pipe_pkg::*;
#(
  parameter int CTRL_W       = CTRL_WIDTH,
  parameter int DEPTH        = 3,
  parameter int FLUSH_STAGES = 2,
  parameter logic [CTRL_W-1:0] BUBBLE_VAL = '0,
  parameter int CNT_W        = 8,
  parameter int MAX_STALL    = 4
) (
  input logic               clk,
  input logic               rst_n,
  ctrl_hazard_pipe_if.slave bus
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

  stage_mode_e       mode  [DEPTH];
  logic [CTRL_W-1:0] st_d  [DEPTH];
  logic [CTRL_W-1:0] st_q  [DEPTH];
  logic              st_dv [DEPTH];
  logic              st_v  [DEPTH];

  logic stall_eff;
  logic breq_eff;
  logic bub_eff;

  assign stall_eff = bus.stall & ~bus.flush;
  assign breq_eff  = bus.bubble_req & ~bus.flush & ~bus.stall;
  assign bub_eff   = stall_eff | breq_eff;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mode[i] = MODE_LOAD;
      unique case (1'b1)
        bus.flush: begin
          if (i < FLUSH_STAGES) mode[i] = MODE_BUBBLE;
        end
        stall_eff: begin
          if (i == 0) mode[i] = MODE_HOLD;
          if (i == 1) mode[i] = MODE_BUBBLE;
        end
        breq_eff: begin
          if (i == 0) mode[i] = MODE_BUBBLE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    st_d[0]  = bus.ctrl_in;
    st_dv[0] = bus.valid_in;
    for (int i = 1; i < DEPTH; i++) begin
      st_d[i]  = st_q[i-1];
      st_dv[i] = st_v[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    ctrl_pipe_stage #(
      .CTRL_W     (CTRL_W),
      .BUBBLE_VAL (BUBBLE_VAL)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .mode_i  (mode[g]),
      .ctrl_i  (st_d[g]),
      .valid_i (st_dv[g]),
      .ctrl_o  (st_q[g]),
      .valid_o (st_v[g])
    );
  end

  logic [DEPTH*CTRL_W-1:0] ctrl_pk;
  logic [DEPTH-1:0]        valid_pk;

  always_comb begin
    ctrl_pk  = '0;
    valid_pk = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ctrl_pk[i*CTRL_W +: CTRL_W] = st_q[i];
      valid_pk[i]                 = st_v[i];
    end
  end

  assign bus.ctrl_out  = ctrl_pk;
  assign bus.valid_out = valid_pk;

  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             to_q, to_d;

  always_comb begin
    bcnt_d = bcnt_q;
    if (bus.cnt_clr) bcnt_d = '0;
    else if (bub_eff && bcnt_q != '1)
      bcnt_d = bcnt_q + 1'b1;

    run_d = '0;
    if (stall_eff)
      run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;

    to_d = to_q;
    if (bus.cnt_clr) to_d = 1'b0;
    else if (stall_eff && run_q == RUN_MAX)
      to_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q <= '0;
      run_q  <= '0;
      to_q   <= 1'b0;
    end else begin
      bcnt_q <= bcnt_d;
      run_q  <= run_d;
      to_q   <= to_d;
    end
  end

  assign bus.bubble_cnt    = bcnt_q;
  assign bus.stall_timeout = to_q;

endmodule

// File: tb/tb_ctrl_hazard_pipe.sv
// Self-checking bench for ctrl_hazard_pipe against a rule-level model.
// Directed scenarios first, then a randomized run.
module tb_ctrl_hazard_pipe;

  localparam int CW = 13;
  localparam int D  = 3;
  localparam int FS = 2;
  localparam int CN = 8;
  localparam int MS = 4;
  localparam int CMAX = 255;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ctrl_hazard_pipe_if #(.CTRL_W(CW), .DEPTH(D), .CNT_W(CN)) bus ();

  ctrl_hazard_pipe #(
    .CTRL_W       (CW),
    .DEPTH        (D),
    .FLUSH_STAGES (FS),
    .BUBBLE_VAL   (13'h0),
    .CNT_W        (CN),
    .MAX_STALL    (MS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [CW-1:0] m_ctrl [D];
  bit            m_v    [D];
  int            m_cnt;
  int            m_run;
  bit            m_to;

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_ctrl[i] = '0;
      m_v[i]    = 1'b0;
    end
    m_cnt = 0;
    m_run = 0;
    m_to  = 1'b0;
  endtask

  // Apply the stated per-edge rules to the current input values.
  task automatic model_step();
    logic [CW-1:0] oc [D];
    bit            ov [D];
    bit            st_e;
    oc = m_ctrl;
    ov = m_v;
    for (int i = 1; i < D; i++) begin
      m_ctrl[i] = oc[i-1];
      m_v[i]    = ov[i-1];
    end
    st_e = bus.stall && !bus.flush;
    if (bus.flush) begin
      for (int i = 0; i < FS; i++) begin
        m_ctrl[i] = '0;
        m_v[i]    = 1'b0;
      end
    end else if (bus.stall) begin
      m_ctrl[0] = oc[0];
      m_v[0]    = ov[0];
      m_ctrl[1] = '0;
      m_v[1]    = 1'b0;
    end else if (bus.bubble_req) begin
      m_ctrl[0] = '0;
      m_v[0]    = 1'b0;
    end else begin
      m_ctrl[0] = bus.valid_in ? bus.ctrl_in : '0;
      m_v[0]    = bus.valid_in;
    end
    if (bus.cnt_clr) m_cnt = 0;
    else if (!bus.flush && (bus.stall || bus.bubble_req))
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    if (bus.cnt_clr) m_to = 1'b0;
    else if (st_e && m_run == MS) m_to = 1'b1;
    m_run = st_e ? ((m_run < MS) ? m_run + 1 : MS) : 0;
  endtask

  function automatic logic [D*CW-1:0] exp_ctrl();
    return {m_ctrl[2], m_ctrl[1], m_ctrl[0]};
  endfunction

  function automatic logic [D-1:0] exp_valid();
    return {m_v[2], m_v[1], m_v[0]};
  endfunction

  task automatic drive(input logic [CW-1:0] c, input bit v,
                       input bit st, input bit br,
                       input bit fl, input bit clr);
    bus.ctrl_in    = c;
    bus.valid_in   = v;
    bus.stall      = st;
    bus.bubble_req = br;
    bus.flush      = fl;
    bus.cnt_clr    = clr;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive('0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #12;
    checks++;
    if (bus.ctrl_out !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h want 0", bus.ctrl_out);
    end
    checks++;
    if (bus.valid_out !== 3'b000) begin
      errors++;
      $display("FAIL reset_valid: got %b want 000", bus.valid_out);
    end
    checks++;
    if (bus.bubble_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d want 0", bus.bubble_cnt);
    end
    checks++;
    if (bus.stall_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_to: got %b want 0", bus.stall_timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    drive(13'h0A5, 1, 0, 0, 0, 0);
    cyc();
    checks++;
    if (bus.ctrl_out[12:0] !== 13'h0A5) begin
      errors++;
      $display("FAIL stream_e1_s0: got %h want 0a5", bus.ctrl_out[12:0]);
    end
    drive(13'h111, 1, 0, 0, 0, 0);
    cyc();
    checks++;
    if (bus.ctrl_out[25:13] !== 13'h0A5) begin
      errors++;
      $display("FAIL stream_e2_s1: got %h want 0a5", bus.ctrl_out[25:13]);
    end
    drive(13'h1FF, 1, 0, 0, 0, 0);
    cyc();
    checks++;
    if (bus.ctrl_out !== {13'h0A5, 13'h111, 13'h1FF}) begin
      errors++;
      $display("FAIL stream_e3: got %h want %h", bus.ctrl_out,
               {13'h0A5, 13'h111, 13'h1FF});
    end
    checks++;
    if (bus.valid_out !== 3'b111) begin
      errors++;
      $display("FAIL stream_valid: got %b want 111", bus.valid_out);
    end
    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.ctrl_out !== '0 || bus.valid_out !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: got %h/%b want 0/000",
               bus.ctrl_out, bus.valid_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stall();
    drive(13'h1FF, 1, 0, 0, 0, 0); cyc();
    drive(13'h111, 1, 0, 0, 0, 0); cyc();
    drive(13'h0A5, 1, 0, 0, 0, 0); cyc();
    drive(13'h333, 1, 1, 0, 0, 0); cyc();
    checks++;
    if (bus.ctrl_out !== {13'h111, 13'h000, 13'h0A5}) begin
      errors++;
      $display("FAIL stall_ctrl: got %h want %h", bus.ctrl_out,
               {13'h111, 13'h000, 13'h0A5});
    end
    checks++;
    if (bus.valid_out !== 3'b101) begin
      errors++;
      $display("FAIL stall_valid: got %b want 101", bus.valid_out);
    end
    checks++;
    if (bus.bubble_cnt !== 8'd1) begin
      errors++;
      $display("FAIL stall_cnt: got %0d want 1", bus.bubble_cnt);
    end
    drive('0, 0, 0, 0, 0, 0); cyc();
  endtask

  task automatic test_flush_vs_stall();
    int c0;
    drive(13'h0C3, 1, 0, 0, 0, 0); cyc();
    drive(13'h0B2, 1, 0, 0, 0, 0); cyc();
    drive(13'h0A1, 1, 0, 0, 0, 0); cyc();
    c0 = m_cnt;
    drive(13'h444, 1, 1, 0, 1, 0); cyc();
    checks++;
    if (bus.ctrl_out !== {13'h0B2, 13'h000, 13'h000}) begin
      errors++;
      $display("FAIL flush_ctrl: got %h want %h", bus.ctrl_out,
               {13'h0B2, 13'h000, 13'h000});
    end
    checks++;
    if (bus.valid_out !== 3'b100) begin
      errors++;
      $display("FAIL flush_valid: got %b want 100", bus.valid_out);
    end
    checks++;
    if (bus.bubble_cnt !== 8'(c0)) begin
      errors++;
      $display("FAIL flush_cnt: got %0d want %0d", bus.bubble_cnt, c0);
    end
    // A flush mid-stall must restart the stall run.
    drive('0, 0, 1, 0, 0, 0);
    repeat (3) cyc();
    drive('0, 0, 1, 0, 1, 0); cyc();
    drive('0, 0, 1, 0, 0, 0);
    repeat (4) cyc();
    checks++;
    if (bus.stall_timeout !== 1'b0) begin
      errors++;
      $display("FAIL flush_run_clr: got %b want 0", bus.stall_timeout);
    end
    cyc();
    checks++;
    if (bus.stall_timeout !== 1'b1) begin
      errors++;
      $display("FAIL flush_run_5th: got %b want 1", bus.stall_timeout);
    end
    drive('0, 0, 0, 0, 0, 1); cyc();
    drive('0, 0, 0, 0, 0, 0); cyc();
  endtask

  task automatic test_bubble_sat();
    drive('0, 0, 0, 0, 0, 1); cyc();
    drive(13'h055, 1, 0, 1, 0, 0);
    repeat (254) cyc();
    checks++;
    if (bus.bubble_cnt !== 8'd254) begin
      errors++;
      $display("FAIL cnt_254: got %0d want 254", bus.bubble_cnt);
    end
    repeat (46) cyc();
    checks++;
    if (bus.bubble_cnt !== 8'd255) begin
      errors++;
      $display("FAIL cnt_sat: got %0d want 255", bus.bubble_cnt);
    end
    checks++;
    if (bus.valid_out !== 3'b000 || bus.ctrl_out !== '0) begin
      errors++;
      $display("FAIL bubble_pipe: got %h/%b want 0/000",
               bus.ctrl_out, bus.valid_out);
    end
    drive(13'h055, 1, 0, 1, 0, 1); cyc();
    checks++;
    if (bus.bubble_cnt !== 8'd0) begin
      errors++;
      $display("FAIL cnt_clr_wins: got %0d want 0", bus.bubble_cnt);
    end
    drive('0, 0, 0, 0, 0, 0); cyc();
  endtask

  task automatic test_timeout();
    drive('0, 0, 0, 0, 0, 1); cyc();
    drive(13'h0F0, 1, 1, 0, 0, 0);
    repeat (4) cyc();
    checks++;
    if (bus.stall_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_4: got %b want 0", bus.stall_timeout);
    end
    cyc();
    checks++;
    if (bus.stall_timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_5: got %b want 1", bus.stall_timeout);
    end
    drive(13'h0F0, 1, 0, 0, 0, 0);
    repeat (2) cyc();
    checks++;
    if (bus.stall_timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_sticky: got %b want 1", bus.stall_timeout);
    end
    drive('0, 0, 1, 0, 0, 1); cyc();
    checks++;
    if (bus.stall_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_clr: got %b want 0", bus.stall_timeout);
    end
    drive('0, 0, 0, 0, 0, 1); cyc();
    drive('0, 0, 1, 0, 0, 0);
    repeat (4) cyc();
    drive('0, 0, 0, 0, 0, 0); cyc();
    drive('0, 0, 1, 0, 0, 0);
    repeat (4) cyc();
    checks++;
    if (bus.stall_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_gap: got %b want 0", bus.stall_timeout);
    end
    drive('0, 0, 0, 0, 0, 0); cyc();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      drive(13'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0));
      cyc();
      checks++;
      if (bus.ctrl_out !== exp_ctrl()) begin
        errors++;
        $display("FAIL rnd_ctrl @%0d: got %h want %h", n,
                 bus.ctrl_out, exp_ctrl());
      end
      checks++;
      if (bus.valid_out !== exp_valid()) begin
        errors++;
        $display("FAIL rnd_valid @%0d: got %b want %b", n,
                 bus.valid_out, exp_valid());
      end
      checks++;
      if (bus.bubble_cnt !== 8'(m_cnt)) begin
        errors++;
        $display("FAIL rnd_cnt @%0d: got %0d want %0d", n,
                 bus.bubble_cnt, m_cnt);
      end
      checks++;
      if (bus.stall_timeout !== m_to) begin
        errors++;
        $display("FAIL rnd_to @%0d: got %b want %b", n,
                 bus.stall_timeout, m_to);
      end
      for (int i = 0; i < D; i++) begin
        checks++;
        if (!bus.valid_out[i] && bus.ctrl_out[i*CW +: CW] !== '0) begin
          errors++;
          $display("FAIL rnd_inv @%0d s%0d: got %h want 0", n, i,
                   bus.ctrl_out[i*CW +: CW]);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_flush_vs_stall();
    test_bubble_sat();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
